// File: rtl/codemem_load_ctrl.sv
// codemem_load_ctrl
//
// Shares one instruction-load stream among N_CORES packet-filter cores.
// A session runs in four steps:
//   1. Halt the selected core.
//   2. Wait for that core to report idle.
//   3. Stream 64-bit instructions into its code memory at incrementing addresses.
//   4. Release the core.
//
// Optional feature macro: CODEMEM_LOAD_BROADCAST_EN.
//   When it is defined, the module gains a load_bcast input, sampled with
//   load_start. A broadcast session halts every core, waits for all of them
//   to be idle, and writes to every code memory at once.
//
// Ports
//   clk, rst           single clock; synchronous active-high reset
//   load_start         pulse; starts a session to load_sel (only seen in IDLE)
//   load_sel           target core index
//   load_bcast         (macro only) broadcast session select
//   load_end           pulse; ends the session (only seen in LOAD)
//   inst_valid         instruction word available
//   inst_data          instruction word
//   inst_ready         controller accepts words this cycle
//   core_idle          per-core stopped status
//   core_halt_req      per-core halt request
//   code_mem_wr_addr   shared code-memory write address
//   code_mem_wr_data   shared code-memory write data
//   code_mem_wr_en     per-core write enable
//   busy               session in progress
//   load_done          one-cycle pulse on error-free session end
//   inst_count         words written in the current/last session
//   err_overflow       sticky; a word arrived after the memory was full
//   err_timeout        sticky; target never went idle, or bad load_sel
module codemem_load_ctrl #(
    parameter int N_CORES         = 4,
    parameter int CODE_ADDR_WIDTH = 10,
    parameter int CODE_DATA_WIDTH = 64,
    parameter int HALT_TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_start,
    input  logic [$clog2(N_CORES)-1:0]   load_sel,
`ifdef CODEMEM_LOAD_BROADCAST_EN
    input  logic                         load_bcast,
`endif
    input  logic                         load_end,
    input  logic                         inst_valid,
    input  logic [CODE_DATA_WIDTH-1:0]   inst_data,
    output logic                         inst_ready,
    input  logic [N_CORES-1:0]           core_idle,
    output logic [N_CORES-1:0]           core_halt_req,
    output logic [CODE_ADDR_WIDTH-1:0]   code_mem_wr_addr,
    output logic [CODE_DATA_WIDTH-1:0]   code_mem_wr_data,
    output logic [N_CORES-1:0]           code_mem_wr_en,
    output logic                         busy,
    output logic                         load_done,
    output logic [CODE_ADDR_WIDTH:0]     inst_count,
    output logic                         err_overflow,
    output logic                         err_timeout
);

    localparam int SEL_W = $clog2(N_CORES);
    localparam int TMR_W = $clog2(HALT_TIMEOUT + 1);

    // The memory is full once the count equals the memory depth.
    localparam logic [CODE_ADDR_WIDTH:0] COUNT_FULL = (CODE_ADDR_WIDTH+1)'(1) << CODE_ADDR_WIDTH;
    localparam logic [TMR_W-1:0]         TMR_LAST   = TMR_W'(HALT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HALT    = 2'd1,
        ST_LOAD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    logic bcast_in;
`ifdef CODEMEM_LOAD_BROADCAST_EN
    assign bcast_in = load_bcast;
`else
    assign bcast_in = 1'b0;
`endif

    state_t                       state_q,    state_d;
    logic [SEL_W-1:0]             target_q,   target_d;
    logic                         bcast_q,    bcast_d;
    logic [TMR_W-1:0]             timer_q,    timer_d;
    logic [CODE_ADDR_WIDTH:0]     count_q,    count_d;
    logic                         err_ovf_q,  err_ovf_d;
    logic                         err_to_q,   err_to_d;
    logic [N_CORES-1:0]           halt_q,     halt_d;
    logic                         ready_q,    ready_d;
    logic [N_CORES-1:0]           wr_en_q,    wr_en_d;
    logic [CODE_ADDR_WIDTH-1:0]   wr_addr_q,  wr_addr_d;
    logic [CODE_DATA_WIDTH-1:0]   wr_data_q,  wr_data_d;
    logic                         busy_q,     busy_d;
    logic                         done_q,     done_d;

    // Core-select mask for a session: one-hot, or every core when broadcasting.
    function automatic logic [N_CORES-1:0] core_mask(input logic [SEL_W-1:0] sel,
                                                     input logic bcast);
        if (bcast)
            return '1;
        return N_CORES'(1) << sel;
    endfunction

    logic target_idle;
    assign target_idle = bcast_q ? (&core_idle) : core_idle[target_q];

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        bcast_d   = bcast_q;
        timer_d   = timer_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q;
        err_to_d  = err_to_q;
        halt_d    = halt_q;
        ready_d   = 1'b0;
        wr_en_d   = '0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (int'(load_sel) >= N_CORES) begin
                        // No such core: refuse the session and flag it.
                        err_to_d = 1'b1;
                    end else begin
                        target_d  = load_sel;
                        bcast_d   = bcast_in;
                        timer_d   = '0;
                        count_d   = '0;
                        err_ovf_d = 1'b0;
                        err_to_d  = 1'b0;
                        halt_d    = core_mask(load_sel, bcast_in);
                        busy_d    = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                if (target_idle) begin
                    ready_d = 1'b1;
                    state_d = ST_LOAD;
                end else if (timer_q == TMR_LAST) begin
                    err_to_d = 1'b1;
                    halt_d   = '0;
                    busy_d   = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            ST_LOAD: begin
                ready_d = 1'b1;
                if (inst_valid && ready_q) begin
                    // Once the memory is full, accepted words are dropped.
                    // The address is the word count, so it never wraps.
                    if (count_q == COUNT_FULL) begin
                        err_ovf_d = 1'b1;
                    end else begin
                        wr_en_d   = core_mask(target_q, bcast_q);
                        wr_addr_d = count_q[CODE_ADDR_WIDTH-1:0];
                        wr_data_d = inst_data;
                        count_d   = count_q + 1'b1;
                    end
                end
                if (load_end) begin
                    // A word accepted in this cycle still lands (trailing write).
                    ready_d = 1'b0;
                    halt_d  = '0;
                    done_d  = !err_ovf_d && !err_to_q;
                    state_d = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            target_q  <= '0;
            bcast_q   <= 1'b0;
            timer_q   <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_to_q  <= 1'b0;
            halt_q    <= '0;
            ready_q   <= 1'b0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            bcast_q   <= bcast_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_to_q  <= err_to_d;
            halt_q    <= halt_d;
            ready_q   <= ready_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign inst_ready       = ready_q;
    assign core_halt_req    = halt_q;
    assign code_mem_wr_addr = wr_addr_q;
    assign code_mem_wr_data = wr_data_q;
    assign code_mem_wr_en   = wr_en_q;
    assign busy             = busy_q;
    assign load_done        = done_q;
    assign inst_count       = count_q;
    assign err_overflow     = err_ovf_q;
    assign err_timeout      = err_to_q;

endmodule

// File: doc/codemem_load_ctrl.md
# codemem_load_ctrl

Sequencing controller that shares one instruction-load stream among N packet-filter cores, each with its own code memory. It halts the selected core, streams 64-bit instructions into that core's code memory at incrementing addresses, then releases the core. It sits between the register-strobe instruction interface and the per-core code-memory write ports.

## Interface
- `N_CORES`, 4: number of filter cores / code memories (2..16).
- `CODE_ADDR_WIDTH`, 10: code memory address width.
- `CODE_DATA_WIDTH`, 64: instruction width.
- `HALT_TIMEOUT`, 1024: max cycles to wait for target core idle.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_start`  in  1  pulse; begins a load session to `load_sel`.
- `load_sel`  in  $clog2(N_CORES)  target core index, sampled with `load_start`.
- `load_end`  in  1  pulse; last instruction delivered, end session.
- `inst_valid`  in  1  instruction word available.
- `inst_data`  in  CODE_DATA_WIDTH  instruction word.
- `inst_ready`  out  1  controller accepts word this cycle.
- `core_idle`  in  N_CORES  per-core "stopped, not fetching" status.
- `core_halt_req`  out  N_CORES  per-core halt request, one-hot or zero.
- `code_mem_wr_addr`  out  CODE_ADDR_WIDTH  shared write address.
- `code_mem_wr_data`  out  CODE_DATA_WIDTH  shared write data.
- `code_mem_wr_en`  out  N_CORES  per-core write enable.
- `busy`  out  1  high in any state other than IDLE.
- `load_done`  out  1  one-cycle pulse at successful session end.
- `inst_count`  out  CODE_ADDR_WIDTH+1  words written in current/last session.
- `err_overflow`  out  1  sticky; write attempted past last address.
- `err_timeout`  out  1  sticky; target core never went idle.

## Operation
- States: IDLE, HALT, LOAD, RELEASE.
- IDLE: `load_start`=1 latches `load_sel` as target, clears `inst_count`, address, both error flags; next state HALT. `load_sel` >= N_CORES: ignored, stays IDLE, sets `err_timeout`.
- HALT: `core_halt_req[target]`=1. When `core_idle[target]`=1 → LOAD. Timeout counter reaching HALT_TIMEOUT → set `err_timeout`, → IDLE (halt released).
- LOAD: `core_halt_req[target]` held; `inst_ready`=1. Each cycle with `inst_valid && inst_ready` writes `inst_data` at current address to target, address += 1, `inst_count` += 1. `load_end` → RELEASE; a word accepted in the same cycle is written first.
- Overflow: when `inst_count` == 2^CODE_ADDR_WIDTH, further accepted words are dropped (no write enable), `err_overflow` set; address does not wrap.
- RELEASE: one cycle; halt dropped; `load_done` pulses only if both error flags clear; → IDLE.
- `load_start` outside IDLE: ignored. `load_end` outside LOAD: ignored.
- Reset: every output to 0, state IDLE, mid-session included; no partial write after the reset edge.

## Timing
- All outputs registered.
- `load_start` at edge t → `busy`/`core_halt_req` high at t+1.
- Idle seen at t → `inst_ready` high at t+1.
- Handshake at t → `code_mem_wr_en`/addr/data valid during t+1, exactly one cycle.
- `load_end` at t → RELEASE at t+1 (halt low, `load_done` high), IDLE at t+2.
- Write latency: 1 cycle. Throughput: 1 word/cycle.
- `code_mem_wr_en` at most one bit set. It is 0 outside LOAD, except for the trailing write after the final handshake.

## Configuration
- `CODEMEM_LOAD_BROADCAST_EN`: defined adds input `load_bcast` (1 bit, sampled with `load_start`). When set, halt is requested on all cores; HALT waits for `&core_idle`. Writes assert all `code_mem_wr_en` bits.
- Undefined: port absent, single-target behaviour only.

## Test plan
- Basic load: start sel=2, core_idle[2] after 3 cycles, 5 words back-to-back, load_end → wr_en=4'b0100 at addrs 0..4, `inst_count`=5, `load_done` one pulse, `busy` low after.
- Gapped valid with load_end coincident on word 3 → 3 writes, addrs 0..2, data in order.
- Timeout: core_idle never high → after HALT_TIMEOUT cycles `err_timeout`=1, halt low, no writes, no `load_done`.
- Overflow with CODE_ADDR_WIDTH=3: 10 words → 8 writes (addr 0..7), `err_overflow`=1, no `load_done`.
- Reset mid-LOAD after 2 words → next cycle all outputs 0, IDLE; new session restarts at addr 0.
- Broadcast (macro on): start with load_bcast=1 → halt_req=4'b1111, waits all idle, writes wr_en=4'b1111.
